sram_wbuf_ctrl: RTL and testbench

- Core-side request front end that sits directly upstream of the external SRAM model and drives its independent W0 (write) and R0 (read) valid/ready ports.
- Posted writes are absorbed into a small in-order write buffer and drained to W0 one at a time.
- Reads go to R0 one at a time. A read that hits a buffered write is forwarded locally from the youngest matching entry, so the core always sees program-order data.

---
 rtl/sram_wbuf_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_wbuf_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_wbuf_ctrl.sv
// Core-side front end for the external SRAM: posted writes go through an in-order
// write buffer drained to W0; reads go to R0 or are forwarded from the buffer.
module sram_wbuf_ctrl #(
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wb_empty,
    output logic [ADDR_W-1:0] W0_addr,
    output logic [DATA_W-1:0] W0_data,
    output logic              W0_valid,
    input  logic              W0_ready,
    output logic [ADDR_W-1:0] R0_addr,
    output logic              R0_valid,
    input  logic              R0_ready,
    input  logic [DATA_W-1:0] R0_data
);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(WB_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_GAP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_GAP, R_RSP} r_state_t;

    // Every channel transfers on a rising edge where its valid and ready are both 1;
    // a raised valid and its address/data stay stable until that edge.
    logic [ADDR_W-1:0] r_buf_addr [WB_DEPTH];
    logic [DATA_W-1:0] r_buf_data [WB_DEPTH];
    logic [PTR_W-1:0]  r_head, r_tail;
    logic [PTR_W:0]    r_count, w_count_nxt;
    w_state_t          r_wstate, w_wstate_nxt;
    r_state_t          r_rstate, w_rstate_nxt;
    logic [ADDR_W-1:0] r_w0_addr, r_r0_addr;
    logic [DATA_W-1:0] r_w0_data, r_rsp_rdata, w_hit_data;
    logic              r_wb_empty;
    logic              w_full, w_push, w_pop, w_rd_acc, w_hit, w_w0_load;

    assign w_full    = (r_count == FULL_CNT);
    assign req_ready = req_write ? !w_full : (r_rstate == R_IDLE);
    assign w_push    = req_valid && req_write && !w_full;
    assign w_pop     = (r_wstate == W_REQ) && W0_ready;
    assign w_rd_acc  = req_valid && !req_write && (r_rstate == R_IDLE);

    assign W0_valid  = (r_wstate == W_REQ);
    assign W0_addr   = r_w0_addr;
    assign W0_data   = r_w0_data;
    assign R0_valid  = (r_rstate == R_REQ);
    assign R0_addr   = r_r0_addr;
    assign rsp_valid = (r_rstate == R_GAP) || (r_rstate == R_RSP);
    assign rsp_rdata = r_rsp_rdata;
    assign wb_empty  = r_wb_empty;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (((PTR_W+1)'(k) < r_count) && (r_buf_addr[r_head + PTR_W'(k)] == req_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_buf_data[r_head + PTR_W'(k)];
            end
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_w0_load    = 1'b0;
        case (r_wstate)
            W_IDLE: if (r_count != '0) begin
                w_wstate_nxt = W_REQ;
                w_w0_load    = 1'b1;
            end
            W_REQ:   if (W0_ready) w_wstate_nxt = W_GAP;
            W_GAP:   w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_rd_acc) w_rstate_nxt = w_hit ? R_RSP : R_REQ;
            R_REQ:   if (R0_ready) w_rstate_nxt = R_GAP;
            R_GAP:   w_rstate_nxt = R_IDLE;
            R_RSP:   w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Entry storage needs no reset: only the first r_count entries from r_head are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_addr[r_tail] <= req_addr;
            r_buf_data[r_tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate    <= W_IDLE;
            r_rstate    <= R_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_w0_addr   <= '0;
            r_w0_data   <= '0;
            r_r0_addr   <= '0;
            r_rsp_rdata <= '0;
            r_wb_empty  <= 1'b1;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_rstate   <= w_rstate_nxt;
            r_count    <= w_count_nxt;
            r_wb_empty <= (w_count_nxt == '0) && (w_wstate_nxt == W_IDLE);
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            if (w_w0_load) begin
                r_w0_addr <= r_buf_addr[r_head];
                r_w0_data <= r_buf_data[r_head];
            end
            if (w_rd_acc) begin
                if (w_hit) r_rsp_rdata <= w_hit_data;
                else       r_r0_addr   <= req_addr;
            end else if ((r_rstate == R_REQ) && R0_ready) begin
                r_rsp_rdata <= R0_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_wbuf_ctrl.sv
// Directed bench for sram_wbuf_ctrl with a small SRAM responder on W0/R0.
module tb_sram_wbuf_ctrl;
    logic        clk, rst_n;
    logic        req_valid, req_write;
    logic [25:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, rsp_valid, wb_empty;
    logic [31:0] rsp_rdata;
    logic [25:0] W0_addr, R0_addr;
    logic [31:0] W0_data, R0_data;
    logic        W0_valid, W0_ready, R0_valid, R0_ready;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int r_cnt = 0;
    int r_lat = 1;
    bit w_stall = 0;
    logic [57:0] w_log[$];
    int          w_hs_cyc[$];
    logic [57:0] w_cur;
    logic [31:0] mem [logic [25:0]];

    sram_wbuf_ctrl #(.ADDR_W(26), .DATA_W(32), .WB_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wb_empty(wb_empty),
        .W0_addr(W0_addr), .W0_data(W0_data), .W0_valid(W0_valid), .W0_ready(W0_ready),
        .R0_addr(R0_addr), .R0_valid(R0_valid), .R0_ready(R0_ready), .R0_data(R0_data)
    );

    // clock / reset
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Unwritten SRAM locations read back a fixed pattern.
    function automatic logic [31:0] pat(input logic [25:0] a);
        return 32'hA500_0000 ^ {6'd0, a};
    endfunction

    // W0 responder: ready for one cycle per request unless stalled; logs each transfer.
    initial begin
        W0_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                W0_ready = 0;
            end else if (W0_ready) begin
                w_log.push_back(w_cur);
                w_hs_cyc.push_back(cyc);
                mem[w_cur[57:32]] = w_cur[31:0];
                check("w0_gap", 32'(W0_valid), 32'd0);
                W0_ready = 0;
            end else if (W0_valid && !w_stall) begin
                W0_ready = 1;
                w_cur = {W0_addr, W0_data};
            end
        end
    end

    // R0 responder: completes r_lat cycles after R0_valid is first seen.
    initial begin
        R0_ready = 0;
        R0_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || R0_ready) begin
                R0_ready = 0;
                r_cnt    = 0;
            end else if (R0_valid) begin
                r_cnt++;
                if (r_cnt >= r_lat) begin
                    R0_ready = 1;
                    R0_data  = mem.exists(R0_addr) ? mem[R0_addr] : pat(R0_addr);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rsp_valid) rsp_cnt++;
    end

    // driver tasks: all start and end at posedge+1
    task automatic do_write(input logic [25:0] a, input logic [31:0] d, output int waits, output int acc);
        req_valid = 1; req_write = 1; req_addr = a; req_wdata = d; waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) check("wr_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 0; req_write = 0;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        @(negedge clk);
        while (!wb_empty && n < 300) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(wb_empty), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_d, input int acc, input int exp_lat);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_rdata, exp_d);
        check({tag, "_lat"}, 32'(cyc - acc), 32'(exp_lat));
    endtask

    task automatic do_read(input logic [25:0] a, input logic [31:0] exp_d, input bit hit, input string tag);
        int n = 0;
        int acc;
        req_valid = 1; req_write = 0; req_addr = a;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) check({tag, "_acc"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 0;
        @(negedge clk);
        check({tag, "_r0v"}, 32'(R0_valid), hit ? 32'd0 : 32'd1);
        if (!hit) check({tag, "_r0a"}, 32'(R0_addr), 32'(a));
        wait_rsp(tag, exp_d, acc, hit ? 0 : r_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int waits, acc, acc2, hs0, rc;
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        #23 rst_n = 1;
        @(posedge clk); #1;

        // reset state
        check("rst_w0v", 32'(W0_valid), 32'd0);
        check("rst_r0v", 32'(R0_valid), 32'd0);
        check("rst_rspv", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_w0a", 32'(W0_addr), 32'd0);
        check("rst_w0d", W0_data, 32'd0);
        check("rst_r0a", 32'(R0_addr), 32'd0);
        check("rst_empty", 32'(wb_empty), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd1);

        // 1: write drains, then a miss read returns the written data
        r_lat = 2;
        do_write(26'h10, 32'hDEADBEEF, waits, acc);
        wait_empty("t1_empty");
        check("t1_wcnt", 32'(w_log.size()), 32'd1);
        check("t1_waddr", 32'(w_log[0][57:32]), 32'h10);
        check("t1_wdata", w_log[0][31:0], 32'hDEADBEEF);
        do_read(26'h10, 32'hDEADBEEF, 0, "t1_rd");
        check("t1_empty_after", 32'(wb_empty), 32'd1);

        // 2: fill with W0 stalled; fifth write waits for the first pop
        w_log.delete(); w_hs_cyc.delete();
        w_stall = 1;
        for (int i = 1; i <= 4; i++) begin
            do_write(26'(i), 32'h100 + 32'(i), waits, acc);
            check("t2_nowait", 32'(waits), 32'd0);
        end
        req_valid = 1; req_write = 1; req_addr = 26'd5; req_wdata = 32'h105;
        @(negedge clk);
        check("t2_full_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        w_stall = 0;
        do_write(26'd5, 32'h105, waits, acc);
        check("t2_after_pop", 32'(acc > w_hs_cyc[0]), 32'd1);
        wait_empty("t2_empty");
        check("t2_wcnt", 32'(w_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t2_order_a", 32'(w_log[i][57:32]), 32'(i + 1));
            check("t2_order_d", w_log[i][31:0], 32'h101 + 32'(i));
        end

        // 3: forwarding from the youngest entry; MSB-different address misses
        w_log.delete(); w_hs_cyc.delete();
        w_stall = 1; r_lat = 1;
        do_write(26'h20, 32'h1111, waits, acc);
        do_write(26'h20, 32'h2222, waits, acc);
        do_read(26'h20, 32'h2222, 1, "t3_fwd");
        do_read(26'h2000020, 32'hA7000020, 0, "t3_msb");
        w_stall = 0;
        wait_empty("t3_empty");
        check("t3_w0", w_log[0][31:0], 32'h1111);
        check("t3_w1", w_log[1][31:0], 32'h2222);
        do_read(26'h20, 32'h2222, 0, "t3_sram");

        // 4: miss with 3-cycle latency, back-to-back read blocked, writes drain meanwhile
        w_log.delete(); w_hs_cyc.delete();
        r_lat = 3;
        do_write(26'h40, 32'h4040, waits, acc);
        do_write(26'h41, 32'h4141, waits, acc);
        do_write(26'h42, 32'h4242, waits, acc);
        hs0 = w_log.size();
        req_valid = 1; req_write = 0; req_addr = 26'h30;
        @(negedge clk);
        check("t4_rd1_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        acc = cyc;
        req_addr = 26'h34;
        @(negedge clk);
        check("t4_rd2_blocked", 32'(req_ready), 32'd0);
        wait_rsp("t4_rd1", 32'hA5000030, acc, 3);
        check("t4_gap_blocked", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("t4_idle_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        acc2 = cyc;
        req_valid = 0;
        check("t4_w_concurrent", 32'(w_log.size() > hs0), 32'd1);
        @(negedge clk);
        wait_rsp("t4_rd2", 32'hA5000034, acc2, 3);
        @(posedge clk); #1;
        wait_empty("t4_empty");
        for (int i = 0; i < 3; i++)
            check("t4_order", 32'(w_log[i][57:32]), 32'h40 + 32'(i));

        // 5: asynchronous reset with both SRAM ports busy and two writes buffered
        w_log.delete(); w_hs_cyc.delete();
        w_stall = 1; r_lat = 20;
        do_write(26'h50, 32'h5555, waits, acc);
        do_write(26'h51, 32'h5151, waits, acc);
        req_valid = 1; req_write = 0; req_addr = 26'h60;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t5_pre_w0v", 32'(W0_valid), 32'd1);
        check("t5_pre_r0v", 32'(R0_valid), 32'd1);
        rc = rsp_cnt;
        #3 rst_n = 0;
        #1;
        check("t5_w0v", 32'(W0_valid), 32'd0);
        check("t5_r0v", 32'(R0_valid), 32'd0);
        check("t5_empty", 32'(wb_empty), 32'd1);
        check("t5_rspv", 32'(rsp_valid), 32'd0);
        check("t5_w0a", 32'(W0_addr), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1;
        repeat (4) @(posedge clk);
        #1;
        check("t5_no_rsp", 32'(rsp_cnt), 32'(rc));
        check("t5_still_empty", 32'(wb_empty), 32'd1);
        check("t5_no_writes", 32'(w_log.size()), 32'd0);
        w_stall = 0; r_lat = 2;
        do_read(26'h50, 32'hA5000050, 0, "t5_rd");

        // 6: push and pop on the same edge at count 2
        w_log.delete(); w_hs_cyc.delete();
        w_stall = 1;
        do_write(26'h70, 32'h7070, waits, acc);
        do_write(26'h71, 32'h7171, waits, acc);
        repeat (3) @(posedge clk);
        #1;
        check("t6_w0v", 32'(W0_valid), 32'd1);
        req_valid = 1; req_write = 1; req_addr = 26'h72; req_wdata = 32'h7272;
        w_stall = 0;
        @(negedge clk);
        check("t6_pp_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 0; req_write = 0;
        w_stall = 1;
        @(posedge clk); #1;
        check("t6_popped", 32'(w_log.size()), 32'd1);
        do_read(26'h72, 32'h7272, 1, "t6_fwd72");
        do_read(26'h71, 32'h7171, 1, "t6_fwd71");
        do_write(26'h73, 32'h7373, waits, acc);
        check("t6_w73_wait", 32'(waits), 32'd0);
        do_write(26'h74, 32'h7474, waits, acc);
        check("t6_w74_wait", 32'(waits), 32'd0);
        req_valid = 1; req_write = 1; req_addr = 26'h75; req_wdata = 32'h7575;
        @(negedge clk);
        check("t6_full_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        w_stall = 0;
        do_write(26'h75, 32'h7575, waits, acc);
        wait_empty("t6_empty");
        check("t6_wcnt", 32'(w_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("t6_order_a", 32'(w_log[i][57:32]), 32'h70 + 32'(i));
            check("t6_order_d", w_log[i][31:0], (32'h70 + 32'(i)) * 32'h101);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
